// File: rtl/adc_spi_pkg.sv
// Shared types and frame geometry for the serial ADC sampler.
// Period numbers below are 1-based SCLK periods within one chip-select frame.
package adc_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    localparam int FRAME_BITS   = 17;
    localparam int CMD_BITS     = 5;
    localparam int NULL_BIT_IDX = 7;
    localparam int DATA_W       = 10;

endpackage

// File: rtl/adc_sclk_divider.sv
// Half-period phase counter for the ADC serial clock.
// Emits strobes on the last clk cycle of each SCLK half period.
module adc_sclk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic sclk_level,
    output logic first_cycle,
    output logic rise_strobe,
    output logic fall_strobe
);

    localparam int PHASE_W = $clog2(CLK_DIV);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
        $error("adc_sclk_divider: CLK_DIV must be in 2..255");
    end

    logic [PHASE_W-1:0] phase;
    logic               half_end;

    assign half_end    = run && (phase == PHASE_W'(CLK_DIV - 1));
    assign first_cycle = run && (phase == '0);
    assign rise_strobe = half_end && !sclk_level;
    assign fall_strobe = half_end && sclk_level;

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values of its neighbours, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else if (!run || half_end) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/adc_spi_sampler.sv
// SPI master for a 10-bit serial ADC: sends a 5-bit channel command, reads the
// null bit and D9..D0, and presents the result as a registered sample.
module adc_spi_sampler
    import adc_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        channel,
    output logic              busy,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              frame_error,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic              adc_mosi,
    input  logic              adc_miso
);

    localparam int BIT_W = $clog2(FRAME_BITS);
    // Keeps the null bit and the ten data bits; earlier MISO bits fall off the top.
    localparam int RX_W  = FRAME_BITS - NULL_BIT_IDX + 1;
    // The IDLE cycle that follows HOLD is the last cs_n-high cycle of the guard,
    // so back-to-back frames see cs_n high for exactly CS_HOLD cycles.
    localparam int HOLD_CYCLES = (CS_HOLD > 1) ? CS_HOLD - 1 : 1;
    localparam int HOLD_W      = $clog2(HOLD_CYCLES + 1);

    state_t              state, state_next;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_next;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_next;
    logic [2:0]          ch_lat, ch_next;
    logic [RX_W-1:0]     rx_shift, rx_next;
    logic                busy_next, cs_n_next, sclk_next, mosi_next;
    logic [DATA_W-1:0]   sample_next;
    logic                valid_next, error_next;

    logic first_cycle, rise_strobe, fall_strobe;

    adc_sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk        (clk),
        .reset      (reset),
        .run        ((state == SETUP) || (state == SHIFT)),
        .sclk_level (adc_sclk),
        .first_cycle(first_cycle),
        .rise_strobe(rise_strobe),
        .fall_strobe(fall_strobe)
    );

    function automatic logic cmd_bit(input logic [2:0] ch, input logic [BIT_W-1:0] idx);
        logic [CMD_BITS-1:0] cmd;
        cmd = {2'b11, ch} << idx;
        return (idx < BIT_W'(CMD_BITS)) ? cmd[CMD_BITS-1] : 1'b0;
    endfunction

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        hold_cnt_next = hold_cnt;
        ch_next       = ch_lat;
        rx_next       = rx_shift;
        sclk_next     = adc_sclk;
        mosi_next     = adc_mosi;
        sample_next   = sample;
        valid_next    = 1'b0;
        error_next    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SETUP;
                    ch_next    = channel;
                end
            end
            SETUP: begin
                // With SCLK still low, the end of the first half period is a rise strobe.
                if (rise_strobe) begin
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                    mosi_next    = cmd_bit(ch_lat, '0);
                end
            end
            SHIFT: begin
                if (adc_sclk && first_cycle) begin
                    rx_next = {rx_shift[RX_W-2:0], adc_miso};
                end
                if (rise_strobe) begin
                    sclk_next = 1'b1;
                end else if (fall_strobe) begin
                    sclk_next = 1'b0;
                    if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                        state_next    = HOLD;
                        hold_cnt_next = '0;
                        mosi_next     = 1'b0;
                        sample_next   = rx_shift[DATA_W-1:0];
                        valid_next    = 1'b1;
                        error_next    = rx_shift[DATA_W];
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                        mosi_next    = cmd_bit(ch_lat, bit_cnt + 1'b1);
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
        cs_n_next = !((state_next == SETUP) || (state_next == SHIFT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            hold_cnt     <= '0;
            ch_lat       <= '0;
            rx_shift     <= '0;
            busy         <= 1'b0;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b0;
            adc_mosi     <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            hold_cnt     <= hold_cnt_next;
            ch_lat       <= ch_next;
            rx_shift     <= rx_next;
            busy         <= busy_next;
            adc_cs_n     <= cs_n_next;
            adc_sclk     <= sclk_next;
            adc_mosi     <= mosi_next;
            sample       <= sample_next;
            sample_valid <= valid_next;
            frame_error  <= error_next;
        end
    end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler: one DUT at CLK_DIV=4 and one at CLK_DIV=2,
// each talking to a small behavioural ADC model.
module tb_adc_spi_sampler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       a_start = 1'b0, b_start = 1'b0;
    logic [2:0] a_channel = 3'd0, b_channel = 3'd0;
    logic       a_busy, a_valid, a_err, a_cs_n, a_sclk, a_mosi;
    logic       b_busy, b_valid, b_err, b_cs_n, b_sclk, b_mosi;
    logic [9:0] a_sample, b_sample;
    logic       a_miso = 1'b0, b_miso = 1'b0;

    int checks = 0;
    int errors = 0;

    // ADC model state: completed SCLK periods in the current frame
    int         a_per = 0, b_per = 0;
    logic [9:0] a_data = 10'h0, b_data = 10'h0;
    logic       a_null = 1'b0, b_null = 1'b0;
    logic [17:0] a_log = '0;

    always #5 clk = ~clk;

    adc_spi_sampler #(.CLK_DIV(4), .CS_HOLD(8)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .channel(a_channel),
        .busy(a_busy), .sample(a_sample), .sample_valid(a_valid), .frame_error(a_err),
        .adc_cs_n(a_cs_n), .adc_sclk(a_sclk), .adc_mosi(a_mosi), .adc_miso(a_miso)
    );

    adc_spi_sampler #(.CLK_DIV(2), .CS_HOLD(8)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .channel(b_channel),
        .busy(b_busy), .sample(b_sample), .sample_valid(b_valid), .frame_error(b_err),
        .adc_cs_n(b_cs_n), .adc_sclk(b_sclk), .adc_mosi(b_mosi), .adc_miso(b_miso)
    );

    // Period 6 is driven high on purpose: the sampler must discard it.
    function automatic logic miso_bit(input int p, input logic nb, input logic [9:0] d);
        if (p == 6) return 1'b1;
        if (p == 7) return nb;
        if (p >= 8 && p <= 17) return d[17-p];
        return 1'b0;
    endfunction

    always @(posedge a_cs_n or negedge a_sclk) begin
        if (a_cs_n === 1'b1) a_per = 0;
        else a_per = a_per + 1;
        a_miso = miso_bit(a_per + 1, a_null, a_data);
    end

    always @(posedge a_sclk) begin
        if (a_per + 1 >= 1 && a_per + 1 <= 17) a_log[a_per+1] = a_mosi;
    end

    always @(posedge b_cs_n or negedge b_sclk) begin
        if (b_cs_n === 1'b1) b_per = 0;
        else b_per = b_per + 1;
        b_miso = miso_bit(b_per + 1, b_null, b_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle_a();
        int n;
        for (n = 0; n < 100 && a_busy !== 1'b0; n++) @(negedge clk);
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle_a: busy=%b required 0", a_busy);
        end
    endtask

    // Starts one frame on DUT A; lat is the cycle number of sample_valid (accept = 0).
    task automatic run_frame_a(input logic [2:0] ch, output int lat, output logic [9:0] val,
                               output logic err, output logic c1_ok);
        wait_idle_a();
        @(negedge clk);
        a_start = 1'b1;
        a_channel = ch;
        @(negedge clk);
        a_start = 1'b0;
        c1_ok = (a_busy === 1'b1) && (a_cs_n === 1'b0);
        lat = -1;
        val = 'x;
        err = 1'bx;
        for (int n = 2; n <= 400; n++) begin
            @(negedge clk);
            if (a_valid === 1'b1) begin
                lat = n;
                val = a_sample;
                err = a_err;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: no sample_valid within 400 cycles");
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({a_cs_n, a_sclk, a_mosi, a_busy, a_sample, a_valid, a_err} !== {4'b1000, 10'h0, 2'b00}) begin
            errors++;
            $display("FAIL reset_a: got %b required %b",
                     {a_cs_n, a_sclk, a_mosi, a_busy, a_sample, a_valid, a_err}, {4'b1000, 10'h0, 2'b00});
        end
        checks++;
        if ({b_cs_n, b_sclk, b_mosi, b_busy, b_sample, b_valid, b_err} !== {4'b1000, 10'h0, 2'b00}) begin
            errors++;
            $display("FAIL reset_b: got %b required %b",
                     {b_cs_n, b_sclk, b_mosi, b_busy, b_sample, b_valid, b_err}, {4'b1000, 10'h0, 2'b00});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_cs_n, a_busy, a_valid} !== 3'b100) begin
            errors++;
            $display("FAIL idle_after_reset: got %b required 100", {a_cs_n, a_busy, a_valid});
        end
    endtask

    task automatic test_single();
        int lat; logic [9:0] val; logic err, c1;
        a_data = 10'h2A5;
        a_null = 1'b0;
        run_frame_a(3'd3, lat, val, err, c1);
        checks++;
        if (!c1) begin errors++; $display("FAIL single_cycle1: busy=1/cs_n=0 not seen in cycle 1"); end
        checks++;
        if (lat != 141) begin errors++; $display("FAIL single_latency: got %0d required 141", lat); end
        checks++;
        if (val !== 10'h2A5) begin errors++; $display("FAIL single_sample: got %h required 2a5", val); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL single_frame_error: got %b required 0", err); end
        checks++;
        if (a_log[17:1] !== 17'h0001B) begin
            errors++;
            $display("FAIL single_mosi: got %b required %b", a_log[17:1], 17'h0001B);
        end
    endtask

    task automatic test_null_error();
        int lat; logic [9:0] val; logic err, c1;
        a_data = 10'h3FF;
        a_null = 1'b1;
        run_frame_a(3'd0, lat, val, err, c1);
        checks++;
        if (val !== 10'h3FF) begin errors++; $display("FAIL null_sample: got %h required 3ff", val); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL null_frame_error: got %b required 1", err); end
        @(negedge clk);
        checks++;
        if ({a_valid, a_err} !== 2'b00) begin
            errors++;
            $display("FAIL null_pulse_width: got %b required 00", {a_valid, a_err});
        end
        a_null = 1'b0;
    endtask

    task automatic test_ignored_start();
        int cnt;
        logic [9:0] val;
        cnt = 0;
        val = 'x;
        a_data = 10'h0C3;
        wait_idle_a();
        @(negedge clk);
        a_start = 1'b1;
        a_channel = 3'd3;
        for (int n = 1; n <= 220; n++) begin
            @(negedge clk);
            a_start = (n == 10 || n == 60);
            a_channel = (n >= 10) ? 3'd5 : 3'd3;
            if (a_valid === 1'b1) begin
                cnt++;
                val = a_sample;
            end
        end
        a_start = 1'b0;
        checks++;
        if (cnt != 1) begin errors++; $display("FAIL ignored_valid_count: got %0d required 1", cnt); end
        checks++;
        if (val !== 10'h0C3) begin errors++; $display("FAIL ignored_sample: got %h required 0c3", val); end
        checks++;
        if (a_log[17:1] !== 17'h0001B) begin
            errors++;
            $display("FAIL ignored_mosi: got %b required %b", a_log[17:1], 17'h0001B);
        end
    endtask

    task automatic test_back_to_back();
        int nv, v1_cyc, v2_cyc, gap;
        logic in_gap;
        logic [9:0] v1, v2;
        nv = 0; v1_cyc = -1; v2_cyc = -1; gap = 0; in_gap = 1'b0;
        v1 = 'x; v2 = 'x;
        a_data = 10'h001;
        wait_idle_a();
        @(negedge clk);
        a_start = 1'b1;
        a_channel = 3'd7;
        for (int n = 1; n <= 700; n++) begin
            @(negedge clk);
            if (a_valid === 1'b1) begin
                nv++;
                if (nv == 1) begin
                    v1_cyc = n; v1 = a_sample; a_data = 10'h200; in_gap = 1'b1;
                end else begin
                    v2_cyc = n; v2 = a_sample; a_start = 1'b0;
                    break;
                end
            end
            if (in_gap) begin
                if (a_cs_n === 1'b1) gap++;
                else in_gap = 1'b0;
            end
        end
        a_start = 1'b0;
        checks++;
        if (nv != 2) begin errors++; $display("FAIL b2b_frames: got %0d valid pulses required 2", nv); end
        checks++;
        if (v1_cyc != 141) begin errors++; $display("FAIL b2b_first_latency: got %0d required 141", v1_cyc); end
        checks++;
        if (v1 !== 10'h001) begin errors++; $display("FAIL b2b_first_sample: got %h required 001", v1); end
        checks++;
        if (gap != 8) begin errors++; $display("FAIL b2b_cs_gap: got %0d required 8", gap); end
        checks++;
        if (v2_cyc - v1_cyc != 148) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d required 148", v2_cyc - v1_cyc);
        end
        checks++;
        if (v2 !== 10'h200) begin errors++; $display("FAIL b2b_second_sample: got %h required 200", v2); end
    endtask

    task automatic test_reset_mid_frame();
        int lat, nval;
        logic [9:0] val; logic err, c1;
        bit reached;
        nval = 0;
        reached = 0;
        a_data = 10'h2AA;
        wait_idle_a();
        @(negedge clk);
        a_start = 1'b1;
        a_channel = 3'd6;
        @(negedge clk);
        a_start = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (a_per == 8 && a_cs_n === 1'b0) begin reached = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!reached) begin errors++; $display("FAIL mid_reach_period9: period 9 not reached"); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({a_cs_n, a_sclk, a_busy, a_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_abort: got %b required 1000", {a_cs_n, a_sclk, a_busy, a_valid});
        end
        repeat (4) begin
            @(negedge clk);
            if (a_valid === 1'b1) nval++;
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (a_valid === 1'b1) nval++;
        end
        checks++;
        if (nval != 0) begin errors++; $display("FAIL mid_no_valid: got %0d pulses required 0", nval); end
        a_data = 10'h0F0;
        run_frame_a(3'd2, lat, val, err, c1);
        checks++;
        if (lat != 141) begin errors++; $display("FAIL mid_next_latency: got %0d required 141", lat); end
        checks++;
        if (val !== 10'h0F0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_next_sample: got %h/%b required 0f0/0", val, err);
        end
        checks++;
        if (a_log[17:1] !== 17'h0000B) begin
            errors++;
            $display("FAIL mid_next_mosi: got %b required %b", a_log[17:1], 17'h0000B);
        end
    endtask

    task automatic test_min_divider();
        int lat, run_len, bad, highs;
        logic prev, seen_rise;
        logic [9:0] val;
        lat = -1; run_len = 1; bad = 0; highs = 0;
        prev = 1'b0; seen_rise = 1'b0; val = 'x;
        b_data = 10'h155;
        b_null = 1'b0;
        @(negedge clk);
        b_start = 1'b1;
        b_channel = 3'd1;
        @(negedge clk);
        b_start = 1'b0;
        for (int n = 2; n <= 200; n++) begin
            @(negedge clk);
            if (b_valid === 1'b1) begin
                lat = n;
                val = b_sample;
                break;
            end
            if (b_sclk === prev) begin
                run_len++;
            end else begin
                if (seen_rise && run_len != 2) bad++;
                if (b_sclk === 1'b1) begin
                    seen_rise = 1'b1;
                    highs++;
                end
                prev = b_sclk;
                run_len = 1;
            end
        end
        checks++;
        if (lat != 71) begin errors++; $display("FAIL mindiv_latency: got %0d required 71", lat); end
        checks++;
        if (val !== 10'h155) begin errors++; $display("FAIL mindiv_sample: got %h required 155", val); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mindiv_phase_len: got %0d bad phases required 0", bad); end
        checks++;
        if (highs != 17) begin errors++; $display("FAIL mindiv_periods: got %0d required 17", highs); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_null_error();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_frame();
        test_min_divider();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
